// File: rtl/sd_pkg.sv
// Shared definitions for the SD serial block and its stimulus environment.
package sd_pkg;

   typedef enum logic {IDLE, SHIFT} src_state_t;

   localparam int SD_WORD_WIDTH = 8;
   localparam int SD_BIT_DIV    = 1;

endpackage

// File: rtl/sd_serial_source.sv
// Parallel-to-serial stimulus source for SD: accepts words over valid/ready and
// shifts them MSB-first on xs, each bit held DIV clocks, words streamed gap-free.
module sd_serial_source
   import sd_pkg::*;
#(
   parameter int   WIDTH    = SD_WORD_WIDTH,
   parameter int   DIV      = SD_BIT_DIV,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             xs,
   output logic             bit_strobe,
   output logic             word_done,
   output logic             busy
);

   localparam int IW = $clog2(WIDTH);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
   localparam logic [DW-1:0] LAST_DIV = DW'(DIV - 1);

   src_state_t       state;
   logic [WIDTH-1:0] shreg;
   logic [IW-1:0]    bit_idx;
   logic [DW-1:0]    div_cnt;

   logic bit_end;
   logic last_cycle;
   logic transfer;

   // Handshake and word-boundary flags depend only on state and counters.
   always_comb begin
      bit_end    = (div_cnt == LAST_DIV);
      last_cycle = (state == SHIFT) && (bit_idx == LAST_IDX) && bit_end;
      load_ready = (state == IDLE) || last_cycle;
      word_done  = last_cycle;
      busy       = (state == SHIFT);
      transfer   = load_valid && load_ready;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_idx    <= '0;
         div_cnt    <= '0;
         xs         <= IDLE_BIT;
         bit_strobe <= 1'b0;
      end else begin
         bit_strobe <= 1'b0;
         if (transfer) begin
            shreg      <= load_data;
            xs         <= load_data[WIDTH-1];
            bit_strobe <= 1'b1;
            bit_idx    <= '0;
            div_cnt    <= '0;
            state      <= SHIFT;
         end else if (state == SHIFT) begin
            if (!bit_end) begin
               div_cnt <= div_cnt + 1'b1;
            end else if (bit_idx != LAST_IDX) begin
               // Rotate rather than zero-fill so the whole register stays live.
               shreg      <= {shreg[WIDTH-2:0], shreg[WIDTH-1]};
               xs         <= shreg[WIDTH-2];
               bit_idx    <= bit_idx + 1'b1;
               div_cnt    <= '0;
               bit_strobe <= 1'b1;
            end else begin
               state   <= IDLE;
               xs      <= IDLE_BIT;
               bit_idx <= '0;
               div_cnt <= '0;
            end
         end
      end
   end

endmodule
